cache4_fa_ctrl: RTL and testbench
=================================

Name: cache4_fa_ctrl

Overview:
- Blocking, 4-way fully-associative, one-word-per-line read cache controller.
- Sits directly upstream of the 4-entry LRU tracker. It drives the tracker's update strobe and used-way index, and consumes its LRU index to pick eviction victims.
- Serves one client read port and issues line fills to a slower memory over a valid/ready request channel plus a response strobe.

Parameters:
- AW, 16, address width (full address stored as tag)
- DW, 16, data word width

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  client read request
- req_addr  in  AW  client read address
- req_ready  out  1  block can accept a request (high only in IDLE)
- resp_valid  out  1  one-cycle pulse, read data valid
- resp_data  out  DW  read data
- mem_rd_valid  out  1  fill request to memory
- mem_rd_addr  out  AW  fill address
- mem_rd_ready  in  1  memory accepts fill request
- mem_resp_valid  in  1  fill data strobe
- mem_resp_data  in  DW  fill data
- lru_we  out  1  LRU update strobe (combinational, one cycle)
- lru_used  out  2  way being touched
- lru_idx  in  2  current LRU way from tracker

Behaviour:
- Storage: 4 ways, each with valid bit, AW-bit tag, DW-bit data.
- Reset:
  - All valid bits cleared; state goes to IDLE.
  - Outputs: req_ready=1 in IDLE; resp_valid=0, resp_data=0, mem_rd_valid=0, mem_rd_addr=0, lru_we=0, lru_used=0.
  - The tracker has no reset; its order after reset is don't-care because invalid ways are filled first.
- States: IDLE, LOOKUP, MEM_REQ, MEM_WAIT.
- IDLE:
  - req_ready=1.
  - On req_valid: latch req_addr into addr_q, go to LOOKUP.
- LOOKUP (combinational compare of addr_q against all valid tags):
  - Hit on way w: lru_we=1, lru_used=w this cycle; at posedge resp_valid<=1, resp_data<=data[w]; go to IDLE.
  - Hit latency: accept at cycle T, resp_valid high in T+2. A new request may be accepted in T+2.
  - Multiple tag matches cannot occur (a tag is only written on a miss); if they do, lowest-index way wins.
  - Miss: go to MEM_REQ.
- MEM_REQ:
  - mem_rd_valid=1, mem_rd_addr=addr_q, held stable until mem_rd_ready.
  - On mem_rd_valid && mem_rd_ready at the same posedge: go to MEM_WAIT.
- MEM_WAIT:
  - Waits indefinitely for mem_resp_valid.
  - Victim = lowest-index invalid way if any; otherwise lru_idx sampled that cycle.
  - On mem_resp_valid:
    - That cycle: lru_we=1, lru_used=victim.
    - At posedge: write valid=1, tag=addr_q, data=mem_resp_data into victim; resp_valid<=1, resp_data<=mem_resp_data; go to IDLE.
- resp_valid is exactly one cycle wide; resp_data holds its value until the next response.
- req_valid outside IDLE is ignored (req_ready=0); the client must hold the request.
- mem_resp_valid outside MEM_WAIT is ignored, including a stale response after reset mid-miss.
- Reset in any state:
  - Abandons the transaction, drops mem_rd_valid next cycle, and produces no response.
  - The miss is not replayed.
- lru_we is never asserted in IDLE, in MEM_REQ, or on a LOOKUP miss.

Optional Feature:
- Macro: CACHE4_STATS_EN.
- When defined, adds outputs hit_count[15:0] and miss_count[15:0]:
  - Counters reset to 0.
  - hit_count increments on each LOOKUP hit; miss_count increments on each LOOKUP miss.
  - Both saturate at 16'hFFFF.
- When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
1. Cold miss: after reset, read 0x0040.
   - Expect mem_rd_valid with addr 0x0040.
   - Return 0xBEEF; expect resp_data=0xBEEF, lru_we with lru_used=0.
   - Re-read 0x0040: hit, resp_valid at T+2, no memory request, lru_used=0.
2. Fill order: misses on 0x10, 0x20, 0x30, 0x40 fill ways 0,1,2,3 in order; all four then hit with their returned data.
3. Eviction:
   - After test 2, read 0x10 (hit, way 0 becomes MRU).
   - Then miss on 0x50: victim = lru_idx = way 1; 0x20 now misses, 0x10 still hits.
4. Backpressure:
   - Hold mem_rd_ready=0 for 5 cycles; mem_rd_valid/addr stay stable; req_ready stays 0 while req_valid is held.
   - A mem_resp_valid pulse during MEM_REQ is ignored.
5. Reset mid-miss:
   - Assert reset in MEM_WAIT; then pulse mem_resp_valid with 0x1234.
   - Expect no resp_valid, all ways invalid, and the next read of any address misses.
6. With CACHE4_STATS_EN: the sequence from test 3 yields hit_count=5 and miss_count=6; counts hold at 0xFFFF under forced saturation.

Source files
------------

// File: rtl/cache4_fa_if.sv
// cache4_fa_if
// Bundles the signals of cache4_fa_ctrl:
//   client side : req_valid, req_addr, req_ready, resp_valid, resp_data
//   memory side : mem_rd_valid, mem_rd_addr, mem_rd_ready, mem_resp_valid, mem_resp_data
//   LRU tracker : lru_we, lru_used (to tracker), lru_idx (from tracker)
// slave  : the cache controller's view.
// master : the surrounding environment (client, memory, tracker).
interface cache4_fa_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          req_valid;
    logic [AW-1:0] req_addr;
    logic          req_ready;
    logic          resp_valid;
    logic [DW-1:0] resp_data;
    logic          mem_rd_valid;
    logic [AW-1:0] mem_rd_addr;
    logic          mem_rd_ready;
    logic          mem_resp_valid;
    logic [DW-1:0] mem_resp_data;
    logic          lru_we;
    logic [1:0]    lru_used;
    logic [1:0]    lru_idx;

    modport slave (
        input  req_valid, req_addr, mem_rd_ready, mem_resp_valid, mem_resp_data, lru_idx,
        output req_ready, resp_valid, resp_data, mem_rd_valid, mem_rd_addr, lru_we, lru_used
    );

    modport master (
        output req_valid, req_addr, mem_rd_ready, mem_resp_valid, mem_resp_data, lru_idx,
        input  req_ready, resp_valid, resp_data, mem_rd_valid, mem_rd_addr, lru_we, lru_used
    );
endinterface

// File: rtl/cache4_fa_ctrl.sv
// cache4_fa_ctrl
// Blocking 4-way fully-associative read cache, one word per line, full
// address used as tag. Hits answer two cycles after acceptance; misses
// issue a fill over mem_rd_* and wait for mem_resp_valid. The victim is the
// lowest-index invalid way, otherwise the external LRU tracker's lru_idx.
// Ports:
//   clk    : clock, all state on posedge
//   reset  : synchronous active-high reset
//   bus    : cache4_fa_if.slave (client, memory and LRU tracker signals)
//   hit_count / miss_count : saturating 16-bit counters, present only when
//                            the macro CACHE4_STATS_EN is defined
module cache4_fa_ctrl #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic        clk,
    input  logic        reset,
    cache4_fa_if.slave  bus
`ifdef CACHE4_STATS_EN
    ,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
`endif
);
    typedef enum logic [1:0] {IDLE, LOOKUP, MEM_REQ, MEM_WAIT} state_t;

    state_t        state_reg, state_next;
    logic [AW-1:0] addr_reg;
    logic [3:0]    valid_reg;
    logic [AW-1:0] tag_reg  [4];
    logic [DW-1:0] data_reg [4];
    logic          resp_valid_reg;
    logic [DW-1:0] resp_data_reg;

    logic [3:0]    match;
    logic          hit;
    logic [1:0]    hit_way;
    logic [1:0]    victim;
    logic          lookup_hit;
    logic          lookup_miss;
    logic          fill;

    // Parallel tag compare against the latched address.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_match
            assign match[gi] = valid_reg[gi] && (tag_reg[gi] == addr_reg);
        end
    endgenerate

    // Lowest index wins for both the hit way and the invalid-way search;
    // loops run downward so the last assignment is the lowest index.
    always_comb begin
        hit_way = 2'd0;
        victim  = bus.lru_idx;
        for (int i = 3; i >= 0; i--) begin
            if (match[i])      hit_way = 2'(i);
            if (!valid_reg[i]) victim  = 2'(i);
        end
    end

    assign hit         = |match;
    assign lookup_hit  = (state_reg == LOOKUP) && hit;
    assign lookup_miss = (state_reg == LOOKUP) && !hit;
    assign fill        = (state_reg == MEM_WAIT) && bus.mem_resp_valid;

    always_comb begin
        state_next       = state_reg;
        bus.req_ready    = 1'b0;
        bus.mem_rd_valid = 1'b0;
        bus.mem_rd_addr  = '0;
        bus.lru_we       = 1'b0;
        bus.lru_used     = 2'd0;
        case (state_reg)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_next = LOOKUP;
            end
            LOOKUP: begin
                if (hit) begin
                    bus.lru_we   = 1'b1;
                    bus.lru_used = hit_way;
                    state_next   = IDLE;
                end else begin
                    state_next   = MEM_REQ;
                end
            end
            MEM_REQ: begin
                bus.mem_rd_valid = 1'b1;
                bus.mem_rd_addr  = addr_reg;
                if (bus.mem_rd_ready) state_next = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (bus.mem_resp_valid) begin
                    bus.lru_we   = 1'b1;
                    bus.lru_used = victim;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            addr_reg       <= '0;
            valid_reg      <= 4'b0000;
            resp_valid_reg <= 1'b0;
            resp_data_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            resp_valid_reg <= 1'b0;
            if ((state_reg == IDLE) && bus.req_valid) addr_reg <= bus.req_addr;
            if (lookup_hit) begin
                resp_valid_reg <= 1'b1;
                resp_data_reg  <= data_reg[hit_way];
            end
            if (fill) begin
                resp_valid_reg    <= 1'b1;
                resp_data_reg     <= bus.mem_resp_data;
                valid_reg[victim] <= 1'b1;
            end
        end
    end

    // Tag/data storage needs no reset: the valid bits gate every use.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_way
            always_ff @(posedge clk) begin
                if (!reset && fill && (victim == 2'(gi))) begin
                    tag_reg[gi]  <= addr_reg;
                    data_reg[gi] <= bus.mem_resp_data;
                end
            end
        end
    endgenerate

    assign bus.resp_valid = resp_valid_reg;
    assign bus.resp_data  = resp_data_reg;

`ifdef CACHE4_STATS_EN
    logic [15:0] hit_count_reg;
    logic [15:0] miss_count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
        end else begin
            if (lookup_hit && (hit_count_reg != 16'hFFFF))
                hit_count_reg <= hit_count_reg + 16'd1;
            if (lookup_miss && (miss_count_reg != 16'hFFFF))
                miss_count_reg <= miss_count_reg + 16'd1;
        end
    end

    assign hit_count  = hit_count_reg;
    assign miss_count = miss_count_reg;
`endif
endmodule

// File: tb/tb_cache4_fa_ctrl.sv
module tb_cache4_fa_ctrl;
    logic clk = 1'b0;
    logic reset;

    cache4_fa_if #(.AW(16), .DW(16)) bus ();

`ifdef CACHE4_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    cache4_fa_ctrl #(.AW(16), .DW(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus)
`ifdef CACHE4_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    logic [15:0] exp_resp [$];
    logic [1:0]  exp_lru  [$];
    logic [15:0] exp_mem  [$];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Simple true-LRU tracker model standing in for the downstream tracker.
    logic [1:0] lru_order [4];
    logic [1:0] lru_next  [4];
    int         lru_pos;

    always_comb begin
        lru_next = lru_order;
        lru_pos  = 0;
        for (int i = 0; i < 4; i++)
            if (lru_order[i] == bus.lru_used) lru_pos = i;
        if (bus.lru_we) begin
            for (int i = 0; i < 3; i++)
                if (i >= lru_pos) lru_next[i] = lru_order[i+1];
            lru_next[3] = bus.lru_used;
        end
    end

    always @(posedge clk) lru_order <= lru_next;
    assign bus.lru_idx = lru_order[0];

    // Monitor: pops expectations whenever the DUT presents an output event.
    logic mem_prev = 1'b0;
    always @(negedge clk) begin
        if (bus.resp_valid) begin
            if (exp_resp.size() == 0) check("unexpected_resp_valid", 32'(bus.resp_valid), 32'd0);
            else check("resp_data", 32'(bus.resp_data), 32'(exp_resp.pop_front()));
        end
        if (bus.lru_we) begin
            if (exp_lru.size() == 0) check("unexpected_lru_we", 32'(bus.lru_we), 32'd0);
            else check("lru_used", 32'(bus.lru_used), 32'(exp_lru.pop_front()));
        end
        if (bus.mem_rd_valid && !mem_prev) begin
            if (exp_mem.size() == 0) check("unexpected_mem_req", 32'(bus.mem_rd_valid), 32'd0);
            else check("mem_rd_addr", 32'(bus.mem_rd_addr), 32'(exp_mem.pop_front()));
        end
        mem_prev <= bus.mem_rd_valid;
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_req_ready",    32'(bus.req_ready),    32'd1);
        check("rst_resp_valid",   32'(bus.resp_valid),   32'd0);
        check("rst_resp_data",    32'(bus.resp_data),    32'd0);
        check("rst_mem_rd_valid", 32'(bus.mem_rd_valid), 32'd0);
        check("rst_mem_rd_addr",  32'(bus.mem_rd_addr),  32'd0);
        check("rst_lru_we",       32'(bus.lru_we),       32'd0);
        check("rst_lru_used",     32'(bus.lru_used),     32'd0);
    endtask

    task automatic wait_mem_req();
        int n = 0;
        while (!bus.mem_rd_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("mem_req_timeout", 32'(bus.mem_rd_valid), 32'd1);
    endtask

    task automatic fill_resp(input logic [15:0] data);
        bus.mem_rd_ready = 1'b1;
        @(negedge clk);
        bus.mem_rd_ready = 1'b0;
        @(negedge clk);
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = data;
        @(negedge clk);
        bus.mem_resp_valid = 1'b0;
        check("miss_resp_valid", 32'(bus.resp_valid), 32'd1);
    endtask

    // One read; expectations go to the scoreboard, the monitor checks them.
    task automatic read_txn(input logic [15:0] addr, input bit miss,
                            input logic [15:0] data, input logic [1:0] way);
        exp_resp.push_back(data);
        exp_lru.push_back(way);
        if (miss) exp_mem.push_back(addr);
        @(negedge clk);
        check("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        if (miss) begin
            wait_mem_req();
            fill_resp(data);
        end else begin
            check("hit_t1_resp_valid", 32'(bus.resp_valid), 32'd0);
            @(negedge clk);
            check("hit_t2_resp_valid", 32'(bus.resp_valid), 32'd1);
            check("hit_t2_req_ready",  32'(bus.req_ready),  32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset              = 1'b1;
        bus.req_valid      = 1'b0;
        bus.req_addr       = '0;
        bus.mem_rd_ready   = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        do_reset();

        // Cold miss then hit.
        read_txn(16'h0040, 1'b1, 16'hBEEF, 2'd0);
        read_txn(16'h0040, 1'b0, 16'hBEEF, 2'd0);

        // Fill order into ways 0..3, then all hit.
        do_reset();
        read_txn(16'h0010, 1'b1, 16'h1111, 2'd0);
        read_txn(16'h0020, 1'b1, 16'h2222, 2'd1);
        read_txn(16'h0030, 1'b1, 16'h3333, 2'd2);
        read_txn(16'h0040, 1'b1, 16'h4444, 2'd3);
        read_txn(16'h0010, 1'b0, 16'h1111, 2'd0);
        read_txn(16'h0020, 1'b0, 16'h2222, 2'd1);
        read_txn(16'h0030, 1'b0, 16'h3333, 2'd2);
        read_txn(16'h0040, 1'b0, 16'h4444, 2'd3);

        // Eviction: 0x10 becomes MRU, 0x50 evicts way 1 (0x20).
        read_txn(16'h0010, 1'b0, 16'h1111, 2'd0);
        read_txn(16'h0050, 1'b1, 16'h5555, 2'd1);
        read_txn(16'h0020, 1'b1, 16'h2222, 2'd2);
`ifdef CACHE4_STATS_EN
        check("hit_count",  32'(hit_count),  32'd5);
        check("miss_count", 32'(miss_count), 32'd6);
`endif
        read_txn(16'h0010, 1'b0, 16'h1111, 2'd0);
        read_txn(16'h0050, 1'b0, 16'h5555, 2'd1);

        // Backpressure on the fill request, with a stray response pulse.
        exp_mem.push_back(16'h0090);
        exp_lru.push_back(2'd3);
        exp_resp.push_back(16'h9999);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 16'h0090;
        @(posedge clk);
        @(negedge clk);
        bus.req_addr  = 16'h00A0;
        wait_mem_req();
        for (int i = 0; i < 5; i++) begin
            check("bp_mem_rd_valid", 32'(bus.mem_rd_valid), 32'd1);
            check("bp_mem_rd_addr",  32'(bus.mem_rd_addr),  32'h0090);
            check("bp_req_ready",    32'(bus.req_ready),    32'd0);
            bus.mem_resp_valid = (i == 2);
            bus.mem_resp_data  = 16'hDEAD;
            @(negedge clk);
        end
        bus.mem_resp_valid = 1'b0;
        bus.req_valid      = 1'b0;
        fill_resp(16'h9999);
        read_txn(16'h0090, 1'b0, 16'h9999, 2'd3);

        // Reset during MEM_WAIT, then a stale response.
        exp_mem.push_back(16'h0070);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 16'h0070;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        wait_mem_req();
        bus.mem_rd_ready = 1'b1;
        @(negedge clk);
        bus.mem_rd_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rmm_mem_rd_valid", 32'(bus.mem_rd_valid), 32'd0);
        check("rmm_req_ready",    32'(bus.req_ready),    32'd1);
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 16'h1234;
        @(negedge clk);
        bus.mem_resp_valid = 1'b0;
        check("rmm_resp_valid", 32'(bus.resp_valid), 32'd0);
        read_txn(16'h0040, 1'b1, 16'h4AAA, 2'd0);
        read_txn(16'h0020, 1'b1, 16'h2BBB, 2'd1);
        read_txn(16'h0040, 1'b0, 16'h4AAA, 2'd0);

`ifdef CACHE4_STATS_EN
        // Saturation: preload both counters at the ceiling.
        @(negedge clk);
        force dut.hit_count_reg  = 16'hFFFF;
        force dut.miss_count_reg = 16'hFFFF;
        @(negedge clk);
        release dut.hit_count_reg;
        release dut.miss_count_reg;
        read_txn(16'h0040, 1'b0, 16'h4AAA, 2'd0);
        read_txn(16'h0060, 1'b1, 16'h6666, 2'd2);
        check("hit_count_sat",  32'(hit_count),  32'hFFFF);
        check("miss_count_sat", 32'(miss_count), 32'hFFFF);
`endif

        repeat (3) @(negedge clk);
        check("resp_queue_empty", 32'(exp_resp.size()), 32'd0);
        check("lru_queue_empty",  32'(exp_lru.size()),  32'd0);
        check("mem_queue_empty",  32'(exp_mem.size()),  32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
